branch_resolve_ctrl: RTL

- Sequences the shared branch comparator for the RV32 core.
- Accepts one decoded conditional branch at a time from ID (valid/ready), waits for forwarded operands and drives the comparator with registered operands and op.
- Checks the outcome against the decoder's static prediction and, on mispredict, issues a flush pulse plus a redirect to fetch (valid/ready).
- Sits between ID/EX and the fetch PC mux.

---
 rtl/branch_resolve_ctrl_if.sv | 48 ++++
 rtl/branch_resolve_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// branch_resolve_ctrl_if: bundles the ID-side branch handshake, operand
// forwarding, comparator drive/return, kill/flush, redirect handshake,
// resolution report and performance counters of branch_resolve_ctrl.
// master = the controller, slave = the surrounding core.
`timescale 1ns/1ps
interface branch_resolve_ctrl_if #(
    parameter int XLEN = 32
);
    logic            br_valid;
    logic            br_ready;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_imm;
    logic [2:0]      br_funct3;
    logic            br_pred_taken;
    logic            ops_valid;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] bc_data1;
    logic [XLEN-1:0] bc_data2;
    logic [2:0]      bc_op;
    logic            bc_out;
    logic            kill;
    logic            flush;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            redir_ready;
    logic            res_valid;
    logic            res_taken;
    logic            res_illegal;
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispred;

    modport master (
        input  br_valid, br_pc, br_imm, br_funct3, br_pred_taken,
        input  ops_valid, rs1_val, rs2_val, bc_out, kill, redir_ready,
        output br_ready, bc_data1, bc_data2, bc_op, flush,
        output redir_valid, redir_pc, res_valid, res_taken, res_illegal,
        output perf_branches, perf_mispred
    );

    modport slave (
        output br_valid, br_pc, br_imm, br_funct3, br_pred_taken,
        output ops_valid, rs1_val, rs2_val, bc_out, kill, redir_ready,
        input  br_ready, bc_data1, bc_data2, bc_op, flush,
        input  redir_valid, redir_pc, res_valid, res_taken, res_illegal,
        input  perf_branches, perf_mispred
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: sequences the shared branch comparator for the RV32
// core. Takes one conditional branch at a time from ID, waits for forwarded
// operands, drives the comparator from registers, compares the outcome with
// the static prediction and on a mispredict pulses flush and raises a
// redirect towards fetch. Optional macro BRANCH_PERF_EN adds saturating
// resolved-branch and mispredict counters; without it both read as zero.
`timescale 1ns/1ps
module branch_resolve_ctrl #(
    parameter int XLEN        = 32,
    parameter int INSTR_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_ctrl_if.master bus
);
    localparam logic [2:0] F3_BEQ = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_OPS,
        S_COMPARE,
        S_EVAL,
        S_REDIRECT
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [2:0]      r_funct3;
    logic            r_pred;
    logic            r_taken;
    logic [XLEN-1:0] r_bc_data1;
    logic [XLEN-1:0] r_bc_data2;
    logic [2:0]      r_bc_op;
    logic [XLEN-1:0] r_redir_pc;

    logic            w_accept;
    logic            w_latch_ops;
    logic            w_sample;
    logic [2:0]      w_f3_src;
    logic [2:0]      w_op_load;
    logic            w_illegal;
    logic            w_taken_now;
    logic [XLEN-1:0] w_target;
    logic            w_mispred;
    logic            w_res_valid;
    logic            w_flush;
    logic            w_redir_valid;

    // funct3 010/011 are not branch encodings
    function automatic logic is_illegal(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    // funct3 arrives from ID in IDLE, from the capture register while waiting
    assign w_f3_src    = (r_state == S_IDLE) ? bus.br_funct3 : r_funct3;
    assign w_op_load   = is_illegal(w_f3_src) ? F3_BEQ : w_f3_src;
    assign w_illegal   = is_illegal(r_funct3);
    assign w_taken_now = bus.bc_out && !w_illegal;
    // target wraps modulo 2^XLEN; carry-out is intentionally discarded
    assign w_target    = w_taken_now ? (r_pc + r_imm) : (r_pc + XLEN'(INSTR_BYTES));
    assign w_mispred   = (r_taken != r_pred);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and handshake strobes; kill aborts every busy state
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_latch_ops = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.br_valid && !bus.kill) begin
                    w_accept = 1'b1;
                    if (bus.ops_valid) begin
                        w_latch_ops = 1'b1;
                        w_next      = S_COMPARE;
                    end else begin
                        w_next = S_WAIT_OPS;
                    end
                end
            end
            S_WAIT_OPS: begin
                if (bus.kill) begin
                    w_next = S_IDLE;
                end else if (bus.ops_valid) begin
                    w_latch_ops = 1'b1;
                    w_next      = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (bus.kill) begin
                    w_next = S_IDLE;
                end else begin
                    w_sample = 1'b1;
                    w_next   = S_EVAL;
                end
            end
            S_EVAL: begin
                // a redirect accepted already in EVAL needs no REDIRECT state
                if (!bus.kill && w_mispred && !bus.redir_ready) begin
                    w_next = S_REDIRECT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REDIRECT: begin
                if (bus.kill || bus.redir_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // branch descriptor capture on accept (payload only, no reset needed)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc     <= bus.br_pc;
            r_imm    <= bus.br_imm;
            r_funct3 <= bus.br_funct3;
            r_pred   <= bus.br_pred_taken;
        end
    end

    // comparator operand/op registers, held stable through COMPARE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bc_data1 <= '0;
            r_bc_data2 <= '0;
            r_bc_op    <= F3_BEQ;
        end else if (w_latch_ops) begin
            r_bc_data1 <= bus.rs1_val;
            r_bc_data2 <= bus.rs2_val;
            r_bc_op    <= w_op_load;
        end
    end

    // sample comparator outcome and redirect target at the end of COMPARE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken    <= 1'b0;
            r_redir_pc <= '0;
        end else if (w_sample) begin
            r_taken    <= w_taken_now;
            r_redir_pc <= w_target;
        end
    end

    assign w_res_valid   = (r_state == S_EVAL) && !bus.kill;
    assign w_flush       = w_res_valid && w_mispred;
    assign w_redir_valid = !bus.kill &&
                           (((r_state == S_EVAL) && w_mispred) || (r_state == S_REDIRECT));

    assign bus.br_ready    = (r_state == S_IDLE);
    assign bus.bc_data1    = r_bc_data1;
    assign bus.bc_data2    = r_bc_data2;
    assign bus.bc_op       = r_bc_op;
    assign bus.res_valid   = w_res_valid;
    assign bus.res_taken   = w_res_valid && r_taken;
    assign bus.res_illegal = w_res_valid && w_illegal;
    assign bus.flush       = w_flush;
    assign bus.redir_valid = w_redir_valid;
    assign bus.redir_pc    = r_redir_pc;

`ifdef BRANCH_PERF_EN
    logic [31:0] r_perf_br;
    logic [31:0] r_perf_mis;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    // saturating counters; killed branches never reach a counted strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_br  <= '0;
            r_perf_mis <= '0;
        end else begin
            if (w_res_valid) r_perf_br  <= sat_inc(r_perf_br);
            if (w_flush)     r_perf_mis <= sat_inc(r_perf_mis);
        end
    end

    assign bus.perf_branches = r_perf_br;
    assign bus.perf_mispred  = r_perf_mis;
`else
    assign bus.perf_branches = '0;
    assign bus.perf_mispred  = '0;
`endif
endmodule
